// File: rtl/pipeline_control_if.sv
// Handshake bundle between the pipeline datapath and its hazard/stall sequencer.
// master = sequencer side, slave = datapath side.
interface pipeline_control_if #(
  parameter int unsigned CNT_W = 16
);
  logic             imem_resp;
  logic             dmem_access;
  logic             dmem_resp;
  logic             load_use;
  logic             br_taken;
  logic             load_pc;
  logic             pc_redirect;
  logic             br_capture;
  logic [3:0]       load_vec;
  logic [3:0]       flush_vec;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    input  imem_resp, dmem_access, dmem_resp, load_use, br_taken,
    output load_pc, pc_redirect, br_capture, load_vec, flush_vec, stall_cnt
  );

  modport slave (
    output imem_resp, dmem_access, dmem_resp, load_use, br_taken,
    input  load_pc, pc_redirect, br_capture, load_vec, flush_vec, stall_cnt
  );
endinterface

// File: rtl/pipeline_control.sv
// Hazard/stall sequencer for the LC-3b 5-stage pipeline: stage-register load/flush,
// PC load/redirect, pending-branch hold while a fetch is outstanding, stall counter.
module pipeline_control #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  pipeline_control_if.master  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    RUN           = 1'b0,
    REDIRECT_HOLD = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       d_stall;
  logic       count_en;
  logic       load_pc;
  logic       pc_redirect;
  logic       br_capture;
  logic [3:0] load_vec;
  logic [3:0] flush_vec;

  assign d_stall = bus.dmem_access & ~bus.dmem_resp;

  // State and stall-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next state; the counter saturates rather than wrapping
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      RUN: begin
        if (!d_stall && bus.br_taken && !bus.imem_resp) state_d = REDIRECT_HOLD;
      end
      REDIRECT_HOLD: begin
        if (bus.imem_resp) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (count_en && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Outputs: zero-latency decode of state and hazard inputs
  always_comb begin
    load_vec    = 4'b0000;
    flush_vec   = 4'b0000;
    load_pc     = 1'b0;
    pc_redirect = 1'b0;
    br_capture  = 1'b0;
    count_en    = 1'b0;
    if (!rst_n) begin
      flush_vec = 4'b1111;
    end else begin
      case (state_q)
        RUN: begin
          if (d_stall) begin
            // MEM is frozen, so a taken branch there simply re-presents next cycle
            count_en = 1'b1;
          end else if (bus.br_taken) begin
            load_vec  = 4'b1000;
            flush_vec = 4'b0111;
            if (bus.imem_resp) begin
              load_pc     = 1'b1;
              pc_redirect = 1'b1;
            end else begin
              br_capture = 1'b1;
              count_en   = 1'b1;
            end
          end else if (bus.load_use) begin
            load_vec  = 4'b1100;
            flush_vec = 4'b0010;
            count_en  = 1'b1;
          end else if (!bus.imem_resp) begin
            load_vec  = 4'b1111;
            flush_vec = 4'b0001;
            count_en  = 1'b1;
          end else begin
            load_vec = 4'b1111;
            load_pc  = 1'b1;
          end
        end
        REDIRECT_HOLD: begin
          // PC address held until the wrong-path fetch returns, then it is flushed
          load_vec  = 4'b1000;
          flush_vec = 4'b0111;
          if (bus.imem_resp) begin
            load_pc     = 1'b1;
            pc_redirect = 1'b1;
          end else begin
            count_en = 1'b1;
          end
        end
        default: begin
          flush_vec = 4'b1111;
        end
      endcase
    end
  end

  assign bus.load_pc     = load_pc;
  assign bus.pc_redirect = pc_redirect;
  assign bus.br_capture  = br_capture;
  assign bus.load_vec    = load_vec;
  assign bus.flush_vec   = flush_vec;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule
